td4_prog_loader: RTL and testbench

- Writable program store that replaces the fixed instruction ROM upstream of the td4 core.
- Accepts a 16-byte program plus a 1-byte checksum over a valid/ready byte stream and stores it in a 16x8 RAM.
- Serves `instr` combinationally from the core's `adr`.
- Holds the core in reset while loading and releases it only after the checksum verifies.

---
 rtl/td4_pkg.sv | 20 ++
 rtl/td4_prog_loader_if.sv | 14 +
 rtl/td4_prog_ram.sv | 29 ++
 rtl/td4_prog_loader.sv | 103 ++++++++++
 tb/tb_td4_prog_loader.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared widths, loader state encoding and the NOP opcode
// for the td4 program loader.
package td4_pkg;

  localparam int TD4_ADR_W     = 4;
  localparam int TD4_DATA_W    = 8;
  localparam int TD4_ROM_DEPTH = 16;

  localparam logic [TD4_DATA_W-1:0] TD4_NOP = 8'h00;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LOAD,
    LD_CHECK,
    LD_HOLD,
    LD_RUN,
    LD_ERROR
  } ld_state_e;

endpackage

// File: rtl/td4_prog_loader_if.sv
// rtl/td4_prog_loader_if.sv - program byte stream into the loader: start pulse
// plus a valid/ready data channel.
interface td4_prog_loader_if;
  import td4_pkg::*;

  logic                  ld_start;
  logic [TD4_DATA_W-1:0] ld_data;
  logic                  ld_valid;
  logic                  ld_ready;

  modport master (output ld_start, output ld_data, output ld_valid, input ld_ready);
  modport slave  (input ld_start, input ld_data, input ld_valid, output ld_ready);

endinterface

// File: rtl/td4_prog_ram.sv
// rtl/td4_prog_ram.sv - 16x8 program store: synchronous write, asynchronous
// read, synchronous clear on active-low reset.
module td4_prog_ram
  import td4_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [TD4_ADR_W-1:0]  wadr_i,
  input  logic [TD4_DATA_W-1:0] wdata_i,
  input  logic [TD4_ADR_W-1:0]  radr_i,
  output logic [TD4_DATA_W-1:0] rdata_o
);

  logic [TD4_DATA_W-1:0] mem_q [TD4_ROM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < TD4_ROM_DEPTH; i++) begin
        mem_q[i] <= TD4_NOP;
      end
    end else if (we_i) begin
      mem_q[wadr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[radr_i];

endmodule

// File: rtl/td4_prog_loader.sv
// rtl/td4_prog_loader.sv - writable instruction store for the td4 core; loads
// 16 bytes plus checksum and keeps the core in reset until the sum verifies.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  td4_prog_loader_if.slave      ld,
  input  logic [TD4_ADR_W-1:0]  adr,
  output logic [TD4_DATA_W-1:0] instr,
  output logic                  cpu_reset,
  output logic                  err,
  output logic                  loaded
);

  localparam logic [TD4_ADR_W-1:0] LAST_ADR  = TD4_ADR_W'(TD4_ROM_DEPTH - 1);
  localparam logic [3:0]           HOLD_LAST = 4'(HOLD_CYCLES - 1);

  ld_state_e             state_q, state_d;
  logic [TD4_ADR_W-1:0]  wptr_q, wptr_d;
  logic [TD4_DATA_W-1:0] sum_q, sum_d;
  logic [3:0]            hcnt_q, hcnt_d;
  logic                  ram_we;
  logic                  accept;
  logic [TD4_DATA_W-1:0] ram_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LD_IDLE;
      wptr_q  <= '0;
      sum_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      sum_q   <= sum_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign accept = ld.ld_valid & ld.ld_ready;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    sum_d   = sum_q;
    hcnt_d  = hcnt_q;
    ram_we  = 1'b0;
    unique case (state_q)
      LD_IDLE, LD_RUN, LD_ERROR: begin
        if (ld.ld_start) begin
          state_d = LD_LOAD;
          wptr_d  = '0;
          sum_d   = '0;
          hcnt_d  = '0;
        end
      end
      LD_LOAD: begin
        if (accept) begin
          ram_we = 1'b1;
          sum_d  = sum_q + ld.ld_data;
          wptr_d = wptr_q + 4'd1;
          if (wptr_q == LAST_ADR) begin
            state_d = LD_CHECK;
          end
        end
      end
      LD_CHECK: begin
        // The checksum byte only steers the FSM; it never lands in the RAM.
        if (accept) begin
          state_d = (ld.ld_data == sum_q) ? LD_HOLD : LD_ERROR;
        end
      end
      LD_HOLD: begin
        if (hcnt_q == HOLD_LAST) begin
          state_d = LD_RUN;
        end else begin
          hcnt_d = hcnt_q + 4'd1;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  assign ld.ld_ready = (state_q == LD_LOAD) || (state_q == LD_CHECK);
  assign cpu_reset   = (state_q != LD_RUN);
  assign loaded      = (state_q == LD_RUN);
  assign err         = (state_q == LD_ERROR);
  assign instr       = (state_q == LD_RUN) ? ram_rdata : TD4_NOP;

  td4_prog_ram u_ram (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (ram_we),
    .wadr_i  (wptr_q),
    .wdata_i (ld.ld_data),
    .radr_i  (adr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_td4_prog_loader.sv
// tb/tb_td4_prog_loader.sv - directed bench for td4_prog_loader with a
// queue-based reference model checked every cycle.
module tb_td4_prog_loader;

  localparam int HOLD = 2;
  localparam int M_IDLE = 0, M_LOAD = 1, M_HOLD = 2, M_RUN = 3, M_ERR = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] adr;
  logic [7:0] instr;
  logic       cpu_reset, err, loaded;

  td4_prog_loader_if ld_if ();

  td4_prog_loader #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld        (ld_if),
    .adr       (adr),
    .instr     (instr),
    .cpu_reset (cpu_reset),
    .err       (err),
    .loaded    (loaded)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // Reference model: collects accepted bytes, judges the load once 17 have arrived.
  int         cyc = 0;
  int         mode = M_IDLE;
  int         rel_at = 0;
  int         s;
  logic [7:0] m_mem [16];
  logic [7:0] m_q [$];

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      mode = M_IDLE;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_q.delete();
    end else begin
      case (mode)
        M_LOAD: begin
          if (ld_if.ld_valid) begin
            m_q.push_back(ld_if.ld_data);
            if (m_q.size() <= 16) begin
              m_mem[m_q.size() - 1] = ld_if.ld_data;
            end else begin
              s = 0;
              for (int i = 0; i < 16; i++) s += m_q[i];
              if (s[7:0] == m_q[16]) begin
                mode   = M_HOLD;
                rel_at = cyc + HOLD;
              end else begin
                mode = M_ERR;
              end
            end
          end
        end
        M_HOLD: if (cyc == rel_at) mode = M_RUN;
        default: begin
          if (ld_if.ld_start) begin
            mode = M_LOAD;
            m_q.delete();
          end
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #2;
    chk("ld_ready", {7'b0, ld_if.ld_ready}, {7'b0, mode == M_LOAD});
    chk("cpu_reset", {7'b0, cpu_reset}, {7'b0, mode != M_RUN});
    chk("loaded", {7'b0, loaded}, {7'b0, mode == M_RUN});
    chk("err", {7'b0, err}, {7'b0, mode == M_ERR});
    chk("instr", instr, (mode == M_RUN) ? m_mem[adr] : 8'h00);
  end

  logic [7:0] stim [$];
  logic [7:0] exp_prog [16];

  task automatic set_prog_a();
    stim = {8'h3F, 8'h40, 8'h30, 8'h70};
    for (int i = 0; i < 12; i++) stim.push_back(8'h00);
    for (int i = 0; i < 16; i++) exp_prog[i] = 8'h00;
    exp_prog[0] = 8'h3F; exp_prog[1] = 8'h40; exp_prog[2] = 8'h30; exp_prog[3] = 8'h70;
  endtask

  task automatic pulse_start();
    @(negedge clk) ld_if.ld_start = 1'b1;
    @(negedge clk) ld_if.ld_start = 1'b0;
  endtask

  task automatic send_all();
    foreach (stim[i]) begin
      @(negedge clk);
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = stim[i];
    end
    @(negedge clk);
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = 8'hEE;
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) adr = 4'(i);
      @(posedge clk) #2;
      chk(name, instr, exp_prog[i]);
    end
  endtask

  initial begin
    int idx, iter;
    reset = 1'b0;
    adr = 4'd0;
    ld_if.ld_start = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = 8'h00;

    // 1: reset then idle sweep
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk) #2;
    chk("s1_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    chk("s1_ld_ready", {7'b0, ld_if.ld_ready}, 8'h00);
    for (int i = 0; i < 16; i++) exp_prog[i] = 8'h00;
    sweep("s1_instr");
    // stray valid bytes in IDLE must be ignored
    @(negedge clk) begin ld_if.ld_valid = 1'b1; ld_if.ld_data = 8'h55; end
    repeat (3) @(negedge clk);
    ld_if.ld_valid = 1'b0;

    // 2: good load, checksum 3F+40+30+70 = 11F -> 1F
    set_prog_a();
    pulse_start();
    chk("s2_ready_after_start", {7'b0, ld_if.ld_ready}, 8'h01);
    stim.push_back(8'h1F);
    send_all();
    @(posedge clk) #2;
    chk("s2_hold_k1", {7'b0, cpu_reset}, 8'h01);
    @(posedge clk) #2;
    chk("s2_release_k2", {7'b0, cpu_reset}, 8'h00);
    chk("s2_loaded", {7'b0, loaded}, 8'h01);
    sweep("s2_instr");
    @(negedge clk) adr = 4'd3;
    #1 chk("s2_lit_adr3", instr, 8'h70);

    // 3: bad checksum
    set_prog_a();
    pulse_start();
    stim.push_back(8'h00);
    send_all();
    adr = 4'd0;
    #1;
    chk("s3_err", {7'b0, err}, 8'h01);
    chk("s3_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    chk("s3_instr", instr, 8'h00);
    pulse_start();
    chk("s3_err_cleared", {7'b0, err}, 8'h00);
    chk("s3_ready", {7'b0, ld_if.ld_ready}, 8'h01);

    // 4: same program with gapped valid and a stray start mid-load
    set_prog_a();
    stim.push_back(8'h1F);
    idx = 0;
    iter = 0;
    while (idx < 17 && iter < 300) begin
      @(negedge clk);
      ld_if.ld_start = (iter == 6);
      if ($urandom_range(0, 1) == 1) begin
        ld_if.ld_valid = 1'b1;
        ld_if.ld_data  = stim[idx];
        idx++;
      end else begin
        ld_if.ld_valid = 1'b0;
        ld_if.ld_data  = 8'hAA;
      end
      iter++;
    end
    chk("s4_stream_done", 8'(idx), 8'd17);
    @(negedge clk) begin ld_if.ld_valid = 1'b0; ld_if.ld_start = 1'b0; end
    repeat (2) @(negedge clk);
    chk("s4_loaded", {7'b0, loaded}, 8'h01);
    sweep("s4_instr");

    // 5: reload from RUN with 16x01, checksum 10
    pulse_start();
    chk("s5_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    chk("s5_loaded", {7'b0, loaded}, 8'h00);
    stim.delete();
    for (int i = 0; i < 16; i++) begin stim.push_back(8'h01); exp_prog[i] = 8'h01; end
    stim.push_back(8'h10);
    send_all();
    repeat (2) @(negedge clk);
    chk("s5_running", {7'b0, cpu_reset}, 8'h00);
    sweep("s5_instr");

    // 6: reset after the 5th accepted byte, then a full good load
    pulse_start();
    stim = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (stim[i]) begin
      @(negedge clk);
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = stim[i];
    end
    @(negedge clk) begin ld_if.ld_valid = 1'b0; reset = 1'b0; end
    @(negedge clk) reset = 1'b1;
    chk("s6_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    chk("s6_ready", {7'b0, ld_if.ld_ready}, 8'h00);
    chk("s6_instr", instr, 8'h00);
    set_prog_a();
    pulse_start();
    stim.push_back(8'h1F);
    send_all();
    repeat (2) @(negedge clk);
    chk("s6_loaded", {7'b0, loaded}, 8'h01);
    sweep("s6_instr");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
